// File: rtl/bcd_scan_display_pkg.sv
// Shared constants for the multiplexed BCD display: digit width and
// active-low seven-segment codes in {g,f,e,d,c,b,a} order.
package bcd_scan_display_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_scan_display_bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder; codes A..F show a dash
// so a corrupted counter digit is visible rather than silently blank.
module bcd_to_7seg
    import bcd_scan_display_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg_n
);

    always_comb begin
        seg_n = SEG_DASH;
        case (bcd)
            4'd0: seg_n = SEG_0;
            4'd1: seg_n = SEG_1;
            4'd2: seg_n = SEG_2;
            4'd3: seg_n = SEG_3;
            4'd4: seg_n = SEG_4;
            4'd5: seg_n = SEG_5;
            4'd6: seg_n = SEG_6;
            4'd7: seg_n = SEG_7;
            4'd8: seg_n = SEG_8;
            4'd9: seg_n = SEG_9;
            default: seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed common-anode driver for NUM_DIGITS BCD digits with a shadow
// register, leading-zero blanking and a blank window at the start of each slot.
module bcd_scan_display
    import bcd_scan_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 2,
    parameter int LZ_BLANK   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    input  logic                        load,
    output logic [6:0]                  seg_n,
    output logic                        dp_n,
    output logic [NUM_DIGITS-1:0]       an_n,
    output logic                        frame_done
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_P    = PW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [BCD_W*NUM_DIGITS-1:0] shadow_digits;
    logic [NUM_DIGITS-1:0]       shadow_dp;
    logic [PW-1:0]               presc;
    logic [IW-1:0]               idx;

    logic                  slot_end;
    logic                  frame_end;
    logic [NUM_DIGITS-1:0] keep;
    logic [BCD_W-1:0]      cur_digit;
    logic                  cur_dp;
    logic                  cur_keep;
    logic [6:0]            dec_seg;
    logic [6:0]            seg_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic                  acc;

    assign slot_end  = (presc == PRESC_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_digits <= '0;
            shadow_dp     <= '0;
            presc         <= '0;
            idx           <= '0;
        end else begin
            if (load) begin
                shadow_digits <= digits_in;
                shadow_dp     <= dp_in;
            end
            presc <= slot_end ? '0 : presc + 1'b1;
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // keep[k] is set when digit k or any digit above it is non-zero; digit 0 always shows.
    always_comb begin
        keep = '1;
        acc  = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            acc     = acc | (shadow_digits[k*BCD_W +: BCD_W] != '0);
            keep[k] = acc || (k == 0) || (LZ_BLANK == 0);
        end
    end

    always_comb begin
        cur_digit = '0;
        cur_dp    = 1'b0;
        cur_keep  = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_digit = shadow_digits[k*BCD_W +: BCD_W];
                cur_dp    = shadow_dp[k];
                cur_keep  = keep[k];
            end
        end
    end

    bcd_to_7seg u_dec (
        .bcd   (cur_digit),
        .seg_n (dec_seg)
    );

    // Segments keep the slot's value during the blank window; only the anodes go dark.
    always_comb begin
        seg_nxt = cur_keep ? dec_seg : SEG_OFF;
        an_nxt  = '1;
        if (presc >= BLANK_P) begin
            an_nxt = ~(NUM_DIGITS'(1) << idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_n      <= SEG_OFF;
            dp_n       <= 1'b1;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            seg_n      <= seg_nxt;
            dp_n       <= ~cur_dp;
            an_n       <= an_nxt;
            frame_done <= frame_end;
        end
    end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Downstream consumer of the synchronous BCD counters: takes NUM_DIGITS packed BCD digits and time-multiplexes them onto one common-anode 7-segment bus.
- Provides a scan prescaler, a digit-select counter and a tear-free shadow register.
- Also provides leading-zero blanking, invalid-code display and anti-ghosting blanking at each slot start.
- Sits between the counter chain and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (2..8).
- SCAN_DIV, 1000: clk cycles per digit slot (>=2).
- BLANK_CYC, 2: cycles at the start of each slot with all anodes off (0 <= BLANK_CYC < SCAN_DIV).
- LZ_BLANK, 1: 1 = suppress leading zeros, 0 = show all digits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- digits_in  in  4*NUM_DIGITS  packed BCD; [3:0] = digit 0 = least significant.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- load  in  1  capture digits_in/dp_in into shadow on this edge.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.
- an_n  out  NUM_DIGITS  digit enables, active-low, at most one low.
- frame_done  out  1  one-cycle pulse when a full scan frame completes.

Behaviour:
- Reset (rst=1 at clk edge):
  - shadow digits = 0, shadow dp = 0, prescaler = 0, index = 0.
  - seg_n = 7'h7F, dp_n = 1, an_n = all 1, frame_done = 0.
  - rst has priority over load.
- Shadow capture:
  - load=1 captures digits_in and dp_in on that edge.
  - Display logic reads only the shadow, never digits_in directly.
  - load while scanning is legal; new data appears from the next output update, with no restart of the scan.
- Prescaler: counts 0..SCAN_DIV-1 and wraps to 0.
- Digit index:
  - Increments when prescaler = SCAN_DIV-1; wraps NUM_DIGITS-1 -> 0.
  - frame_done = 1 for exactly the cycle in which the index register changes from NUM_DIGITS-1 to 0.
- Outputs:
  - All outputs are registered, recomputed every cycle from the current shadow, index and prescaler.
  - Latency is 1 cycle after the state registers; load -> seg_n change takes 2 edges.
- Anti-ghost:
  - While the registered prescaler is < BLANK_CYC, an_n = all 1 and seg_n/dp_n are still driven with the slot's values.
  - Otherwise an_n has a single 0 at bit [index].
- Decode table (seg_n):
  - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19.
  - 5 = 7'h12, 6 = 7'h02, 7 = 7'h78, 8 = 7'h00, 9 = 7'h10.
- Invalid codes A..F: seg_n = 7'h3F (segment g only, dash); dp is unaffected.
- Leading-zero blanking (LZ_BLANK=1):
  - Digit k is blanked (seg_n = 7'h7F) iff it and every digit above it are 0.
  - Digit 0 is never blanked.
  - Invalid codes count as non-zero.
  - The anode is still enabled on a blanked digit; dp_n still follows dp_in for that digit.
- Boundary: SCAN_DIV-1 and index wrap coinciding (end of frame) produce both wraps in the same edge; no skipped or doubled slot.

Decomposition:
- Shared package holds:
  - the seven-segment code constants SEG_0..SEG_9, SEG_DASH and SEG_OFF;
  - the BCD digit width constant (4).
- One sub-module, bcd_to_7seg: purely combinational 4-bit BCD -> 7-bit active-low code, including the dash for A..F.
- The top level holds all counters, the shadow, blanking logic and output registers.

Test Plan:
- Use NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1 throughout.
- Reset: hold rst 3 cycles -> seg_n=7'h7F, an_n=4'hF, dp_n=1, frame_done=0; first frame_done pulse 16 cycles after rst release.
- Scan order: load digits_in=16'h1234, dp_in=4'b0010 -> per slot:
  - 1 cycle an_n=F;
  - then an_n 1110 with seg_n=7'h19 ("4"), 1101 with 7'h30 ("3") and dp_n=0, 1011 with 7'h24 ("2"), 0111 with 7'h79 ("1");
  - repeating.
- Leading zeros: load 16'h0050 -> digits 3 and 2 give seg_n=7'h7F, digit 1 gives 7'h12, digit 0 gives 7'h40. Load 16'h0000 -> only digit 0 lit (7'h40).
- Invalid code: load 16'h00A0 -> digit 1 gives seg_n=7'h3F and digit 0 gives 7'h40; digits 3 and 2 are blanked.
- Mid-frame load and reset:
  - load 16'h9999 during slot 2 -> seg_n=7'h10 from 2 edges later, with the scan phase unchanged.
  - Assert rst mid-slot -> next edge gives all outputs at reset values and index=0.
  - load asserted together with rst -> shadow stays 0.
